// File: rtl/fb_axi_pkg.sv
// rtl/fb_axi_pkg.sv - shared constants, state types and address-advance helper for fb_axi_reg_slave
package fb_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // WRAP is advanced like INCR: the register window never crosses a wrap boundary in use.
    function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                   input logic [1:0]  burst,
                                                   input logic [63:0] step);
        return (burst == BURST_FIXED) ? addr : addr + step;
    endfunction

endpackage

// File: rtl/fb_axi_reg_slave.sv
// rtl/fb_axi_reg_slave.sv - AXI4 slave register bank with RO status slots and per-register write pulses
module fb_axi_reg_slave
    import fb_axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 40,
    parameter int                    ID_WIDTH   = 6,
    parameter int                    N_REGS     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'hA0000000,
    parameter logic [N_REGS-1:0]     RO_MASK    = '0
) (
    input  logic                                clk,
    input  logic                                rstn,

    input  logic [ID_WIDTH-1:0]                 s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]               s_axi_awaddr,
    input  logic [7:0]                          s_axi_awlen,
    input  logic [2:0]                          s_axi_awsize,
    input  logic [1:0]                          s_axi_awburst,
    input  logic                                s_axi_awlock,
    input  logic [3:0]                          s_axi_awcache,
    input  logic [2:0]                          s_axi_awprot,
    input  logic                                s_axi_awvalid,
    output logic                                s_axi_awready,

    input  logic [DATA_WIDTH-1:0]               s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]             s_axi_wstrb,
    input  logic                                s_axi_wlast,
    input  logic                                s_axi_wvalid,
    output logic                                s_axi_wready,

    output logic [ID_WIDTH-1:0]                 s_axi_bid,
    output logic [1:0]                          s_axi_bresp,
    output logic                                s_axi_bvalid,
    input  logic                                s_axi_bready,

    input  logic [ID_WIDTH-1:0]                 s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]               s_axi_araddr,
    input  logic [7:0]                          s_axi_arlen,
    input  logic [2:0]                          s_axi_arsize,
    input  logic [1:0]                          s_axi_arburst,
    input  logic                                s_axi_arlock,
    input  logic [3:0]                          s_axi_arcache,
    input  logic [2:0]                          s_axi_arprot,
    input  logic                                s_axi_arvalid,
    output logic                                s_axi_arready,

    output logic [ID_WIDTH-1:0]                 s_axi_rid,
    output logic [DATA_WIDTH-1:0]               s_axi_rdata,
    output logic [1:0]                          s_axi_rresp,
    output logic                                s_axi_rlast,
    output logic                                s_axi_rvalid,
    input  logic                                s_axi_rready,

    output logic [N_REGS-1:0][DATA_WIDTH-1:0]   reg_q,
    output logic [N_REGS-1:0]                   reg_wr,
    input  logic [N_REGS-1:0][DATA_WIDTH-1:0]   hw_status
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> LSB) < ADDR_WIDTH'(N_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[LSB +: IDX_W];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0]            burst);
        logic [63:0] n;
        n = next_beat_addr(64'(a), burst, 64'(BYTES));
        return n[ADDR_WIDTH-1:0];
    endfunction

    // Write channel state
    wr_state_t             w_state;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [7:0]            wlen;
    logic [7:0]            wcnt;
    logic [1:0]            wburst;
    logic                  werr;

    logic                  w_fire;
    logic                  w_in;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_ro;

    always_comb begin
        w_fire = s_axi_wvalid && s_axi_wready;
        w_in   = in_window(waddr);
        w_idx  = index_of(waddr);
        w_ro   = RO_MASK[w_idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state       <= W_IDLE;
            waddr         <= '0;
            wlen          <= '0;
            wcnt          <= '0;
            wburst        <= '0;
            werr          <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        s_axi_bid     <= s_axi_awid;
                        waddr         <= s_axi_awaddr;
                        wlen          <= s_axi_awlen;
                        wburst        <= s_axi_awburst;
                        wcnt          <= '0;
                        werr          <= 1'b0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr <= advance(waddr, wburst);
                        wcnt  <= wcnt + 8'd1;
                        if (!w_in) werr <= 1'b1;
                        // Termination follows the beat count, not wlast.
                        if (wcnt == wlen) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (werr || !w_in) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_q  <= '0;
            reg_wr <= '0;
        end else begin
            reg_wr <= '0;
            if (w_fire && w_in && !w_ro) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (s_axi_wstrb[b]) reg_q[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
                reg_wr[w_idx] <= 1'b1;
            end
        end
    end

    // Read channel state
    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [7:0]            rlen;
    logic [7:0]            rcnt;
    logic [1:0]            rburst;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_in;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;

    // In idle the beat-0 data comes straight from araddr so it is registered on the AR edge.
    always_comb begin
        rd_addr = (r_state == R_IDLE) ? s_axi_araddr : raddr;
        rd_in   = in_window(rd_addr);
        rd_idx  = index_of(rd_addr);
        rd_val  = '0;
        if (rd_in) rd_val = RO_MASK[rd_idx] ? hw_status[rd_idx] : reg_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= R_IDLE;
            raddr         <= '0;
            rlen          <= '0;
            rcnt          <= '0;
            rburst        <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= rd_val;
                        s_axi_rresp   <= rd_in ? RESP_OKAY : RESP_SLVERR;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        raddr         <= advance(s_axi_araddr, s_axi_arburst);
                        rlen          <= s_axi_arlen;
                        rburst        <= s_axi_arburst;
                        rcnt          <= '0;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            s_axi_rdata <= rd_val;
                            s_axi_rresp <= rd_in ? RESP_OKAY : RESP_SLVERR;
                            s_axi_rlast <= ((rcnt + 8'd1) == rlen);
                            rcnt        <= rcnt + 8'd1;
                            raddr       <= advance(raddr, rburst);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                             s_axi_wlast};

endmodule
